// File: rtl/router_ingress_pkg.sv
// Shared types for the router ingress/egress path.
// Packet layout, field widths and rx FSM states.
package router_ingress_pkg;

  localparam int PKT_BYTES = 4;
  localparam int SRC_W     = 4;
  localparam int DEST_W    = 4;
  localparam int DATA_W    = 24;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DISCARD
  } rx_state_e;

endpackage

// File: rtl/pkt_fifo.sv
// First-word fall-through packet FIFO.
// Shared by ingress and egress stages.
module pkt_fifo
  import router_ingress_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  pkt_t                       pkt,
  input  logic                       pop,
  output pkt_t                       head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  pkt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= pkt;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_ingress.sv
// Router receive port: byte deserializer, packet FIFO,
// one-hot crossbar request and free/put flow control.
module router_ingress
  import router_ingress_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 put_in,
  input  logic [7:0]           payload_in,
  output logic                 free_out,
  output pkt_t                 pkt_out,
  output logic                 pkt_valid,
  output logic [NUM_PORTS-1:0] req,
  input  logic                 grant,
  output logic                 err_pulse
);

  localparam int CW = $clog2(DEPTH+1);

  rx_state_e       state;
  rx_state_e       state_n;
  logic [1:0]      cnt;
  logic [1:0]      cnt_n;
  logic [23:0]     shreg;
  logic [23:0]     shreg_n;
  logic            flush;
  logic            err_n;
  logic            push;
  logic            dest_ok;
  pkt_t            rx_pkt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            room;

  assign rx_pkt  = pkt_t'({shreg, payload_in});
  assign dest_ok = int'(rx_pkt.dest) < NUM_PORTS;

  assign room      = !fifo_full && (fifo_count < CW'(DEPTH));
  assign free_out  = (state == IDLE) && room;
  assign pkt_valid = !fifo_empty;
  assign req       = pkt_valid ? (NUM_PORTS'(1) << pkt_out.dest) : '0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    push    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (put_in && !flush) begin
          if (free_out) begin
            state_n = RECV;
            shreg_n = {16'b0, payload_in};
            cnt_n   = 2'd1;
          end else begin
            state_n = DISCARD;
          end
        end
      end
      RECV: begin
        if (put_in) begin
          shreg_n = {shreg[15:0], payload_in};
          cnt_n   = cnt + 2'd1;
          if (cnt == 2'(PKT_BYTES-1)) begin
            state_n = IDLE;
            cnt_n   = 2'd0;
            push    = dest_ok;
            err_n   = !dest_ok;
          end
        end else begin
          state_n = IDLE;
          cnt_n   = 2'd0;
          err_n   = 1'b1;
        end
      end
      DISCARD: begin
        if (!put_in) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      shreg     <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      err_pulse <= err_n;
    end
  end

  // Swallow the tail of a burst cut short by reset, silently
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush <= 1'b1;
    end else if (!put_in) begin
      flush <= 1'b0;
    end
  end

  pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (push),
    .pkt   (rx_pkt),
    .pop   (grant),
    .head  (pkt_out),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_router_ingress.sv
// Directed bench for router_ingress with a packet scoreboard.
// Expected packets queue on send, compare on grant.
module tb_router_ingress;
  import router_ingress_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       put_in;
  logic [7:0] payload_in;
  logic       free_out;
  pkt_t       pkt_out;
  logic       pkt_valid;
  logic [3:0] req;
  logic       grant;
  logic       err_pulse;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [31:0] sb[$];

  router_ingress #(
    .NUM_PORTS (4),
    .DEPTH     (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .put_in     (put_in),
    .payload_in (payload_in),
    .free_out   (free_out),
    .pkt_out    (pkt_out),
    .pkt_valid  (pkt_valid),
    .req        (req),
    .grant      (grant),
    .err_pulse  (err_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=pop expected=empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(pkt_valid), 32'd1);
      chk({tag, "_pkt"}, pkt_out, e);
      chk({tag, "_req"}, 32'(req), 32'd1 << e[27:24]);
    end
  endtask

  task automatic pop(input string tag);
    grant = 1'b1;
    pop_check(tag);
    tick();
    grant = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int nb,
                      input bit grant_last, input bit expect_push);
    for (int i = 0; i < nb; i++) begin
      put_in     = 1'b1;
      payload_in = w[31-8*i -: 8];
      if (grant_last && i == nb-1) begin
        grant = 1'b1;
        pop_check("gl");
      end
      if (expect_push && i == nb-1) sb.push_back(w);
      tick();
      grant = 1'b0;
    end
    put_in = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    put_in     = 1'b0;
    payload_in = 8'h00;
    grant      = 1'b0;
    tick();
    tick();
    chk("rst_free", 32'(free_out), 32'd1);
    chk("rst_valid", 32'(pkt_valid), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_pkt", pkt_out, 32'd0);
    reset_n = 1'b1;
    tick();

    // single packet
    send(32'h13ABCDEF, 4, 0, 1);
    chk("t1_valid", 32'(pkt_valid), 32'd1);
    chk("t1_req", 32'(req), 32'h8);
    chk("t1_free", 32'(free_out), 32'd1);
    chk("t1_err", 32'(err_pulse), 32'd0);
    pop("t1");
    chk("t1_valid0", 32'(pkt_valid), 32'd0);
    chk("t1_req0", 32'(req), 32'd0);
    chk("t1_free1", 32'(free_out), 32'd1);

    // fill to full, drain one, refill
    send(32'h20111111, 4, 0, 1);
    tick();
    send(32'h31222222, 4, 0, 1);
    chk("t2_full", 32'(free_out), 32'd0);
    pop("t2a");
    chk("t2_free", 32'(free_out), 32'd1);
    send(32'h42333333, 4, 0, 1);
    pop("t2b");
    pop("t2c");
    chk("t2_empty", 32'(pkt_valid), 32'd0);

    // push and pop on the same edge
    send(32'h53444444, 4, 0, 1);
    tick();
    send(32'h60555555, 4, 1, 1);
    chk("t3_valid", 32'(pkt_valid), 32'd1);
    chk("t3_free", 32'(free_out), 32'd1);
    chk("t3_err", 32'(err_pulse), 32'd0);
    pop("t3");
    chk("t3_empty", 32'(pkt_valid), 32'd0);

    // burst aborted after two bytes
    send(32'h7A000000, 2, 0, 0);
    tick();
    chk("t4_err", 32'(err_pulse), 32'd1);
    chk("t4_valid", 32'(pkt_valid), 32'd0);
    chk("t4_free", 32'(free_out), 32'd1);
    tick();
    chk("t4_err0", 32'(err_pulse), 32'd0);
    send(32'h81999999, 4, 0, 1);
    pop("t4");

    // destination out of range
    send(32'h15000001, 4, 0, 0);
    chk("t5_err", 32'(err_pulse), 32'd1);
    chk("t5_valid", 32'(pkt_valid), 32'd0);
    tick();
    chk("t5_err0", 32'(err_pulse), 32'd0);
    chk("t5_valid0", 32'(pkt_valid), 32'd0);

    // put while not free is dropped
    send(32'h92AAAAAA, 4, 0, 1);
    tick();
    send(32'hA3BBBBBB, 4, 0, 1);
    chk("td_full", 32'(free_out), 32'd0);
    send(32'hB0CCCCCC, 4, 0, 0);
    chk("td_err_early", 32'(err_pulse), 32'd0);
    tick();
    chk("td_err", 32'(err_pulse), 32'd1);
    tick();
    chk("td_err0", 32'(err_pulse), 32'd0);
    pop("td_a");
    pop("td_b");
    chk("td_empty", 32'(pkt_valid), 32'd0);

    // reset in the middle of a burst
    send(32'hE1123456, 4, 0, 1);
    tick();
    put_in     = 1'b1;
    payload_in = 8'hC1;
    tick();
    reset_n    = 1'b0;
    payload_in = 8'hC2;
    sb.delete();
    #1;
    chk("t6_valid", 32'(pkt_valid), 32'd0);
    chk("t6_free", 32'(free_out), 32'd1);
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_err", 32'(err_pulse), 32'd0);
    chk("t6_pkt", pkt_out, 32'd0);
    tick();
    reset_n    = 1'b1;
    payload_in = 8'hC3;
    tick();
    chk("t6_err3", 32'(err_pulse), 32'd0);
    chk("t6_valid3", 32'(pkt_valid), 32'd0);
    payload_in = 8'hC4;
    tick();
    chk("t6_err4", 32'(err_pulse), 32'd0);
    chk("t6_valid4", 32'(pkt_valid), 32'd0);
    put_in = 1'b0;
    tick();
    chk("t6_err5", 32'(err_pulse), 32'd0);
    chk("t6_valid5", 32'(pkt_valid), 32'd0);
    tick();
    chk("t6_err6", 32'(err_pulse), 32'd0);
    send(32'hD2EEEEEE, 4, 0, 1);
    pop("t6");
    chk("t6_empty", 32'(pkt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_ingress.md
Name: router_ingress

Overview:
Router-side receive port that sits directly downstream of a node's outbound serial link.
- Deserializes 4-byte bursts (MSB byte first) into pkt_t packets.
- Buffers packets in a small FIFO.
- Presents the head packet with a one-hot destination request to the router crossbar/arbiter, which pops it with a grant.
- Drives the free/put flow control seen by the node.

Parameters:
NUM_PORTS, 4, number of router output ports; width of req; valid dest range 0..NUM_PORTS-1
DEPTH, 2, packet FIFO depth in whole packets (>=1)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
put_in  input  1  node is driving a payload byte this cycle
payload_in  input  8  serial payload byte from node
free_out  output  1  router port can accept a new packet (node samples before starting a burst)
pkt_out  output  pkt_t(32)  head-of-FIFO packet
pkt_valid  output  1  pkt_out holds a valid packet
req  output  NUM_PORTS  one-hot of pkt_out.dest when pkt_valid, else 0
grant  input  1  arbiter accepts head packet; pop on this edge
err_pulse  output  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset (async): rx state IDLE, byte count 0, FIFO empty.
  - Outputs at reset: free_out=1 (DEPTH>=1), pkt_valid=0, req=0, err_pulse=0, pkt_out=0.
  - Reset mid-burst discards the partial packet; remaining put_in bytes of that burst are discarded as an aborted burst, with no err_pulse, until put_in drops.
- Packet format (pkt_t, 32 bits): [31:28] src, [27:24] dest, [23:0] data.
  - Byte order on the wire: [31:24] first, [7:0] last.
- Rx FSM, with states IDLE, RECV and DISCARD:
  - IDLE -> RECV when put_in=1. Byte 0 is captured and the count goes to 1.
  - In RECV, each put_in=1 cycle captures the next byte.
  - After the 4th byte: if dest < NUM_PORTS, the packet is pushed at that same edge; otherwise it is dropped with err_pulse. Either way the FSM returns to IDLE at that edge.
  - put_in=0 in RECV with count < 4: partial packet dropped, err_pulse, -> IDLE.
  - put_in=1 in IDLE while free_out=0 is a protocol violation: -> DISCARD; burst consumed and dropped; err_pulse on the cycle put_in falls; -> IDLE.
- free_out is combinational from registered state: (state==IDLE) && (fifo_count < DEPTH).
  - Because free_out is checked only in IDLE and count cannot grow during RECV, a push never meets a full FIFO.
  - Timing: node samples free at cycle t, bytes arrive t+1..t+4, push at end of t+4, and free_out reflects the new count at t+5.
  - Back-to-back throughput is therefore one packet per 5 cycles.
- Output side:
  - pkt_valid = !empty.
  - pkt_out = FIFO head (0 when empty).
  - req = pkt_valid ? (1 << pkt_out.dest) : 0.
  - grant && pkt_valid pops at the edge; grant without pkt_valid is ignored.
- Simultaneous push and pop: count unchanged. When full with a pop in the same cycle as a push, order is preserved.
- FIFO read is first-word fall-through: a pushed packet is visible on pkt_out the cycle after the push edge (when empty).
- err_pulse is registered, exactly one cycle per discarded packet.

Decomposition:
- RouterPkg holds:
  - the pkt_t packed struct (src, dest, data);
  - PKT_BYTES=4;
  - SRC_W=4, DEST_W=4, DATA_W=24;
  - the rx state enum (IDLE, RECV, DISCARD).
- One sub-module, pkt_fifo:
  - parameterized DEPTH, first-word fall-through, pkt_t entries;
  - ports: push, pop, head, count, empty, full;
  - reusable by the egress stage.
- The deserializer FSM and request decode stay in router_ingress.

Test Plan:
1. Single packet: free_out=1, put_in high 4 cycles with bytes 13,AB,CD,EF -> pkt_valid=1 next cycle, pkt_out=32'h13ABCDEF, req=4'b1000; grant one cycle -> pkt_valid=0, req=0, free_out=1.
2. Back-to-back fill (DEPTH=2, no grant): two packets at 5-cycle spacing -> free_out=0 from the cycle after the 2nd push; a grant -> free_out=1 the next cycle; a third packet is then accepted in order.
3. Push with pop: FIFO holds 1 packet, grant asserted on the same edge as the 4th byte of the next packet -> count stays 1, pkt_out becomes the new packet, no err_pulse.
4. Abort: put_in drops after 2 bytes -> err_pulse one cycle, no push, free_out=1; the following full packet is received correctly.
5. Invalid dest: bytes 15,00,00,01 with NUM_PORTS=4 -> dropped, err_pulse=1 one cycle, pkt_valid stays 0.
6. Reset mid-burst: assert reset_n=0 after byte 1 -> all outputs at reset values immediately, FIFO empty, the rest of the burst is discarded with no push and no err_pulse, and the next packet is received correctly.
